// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppu_pkg
// Brief    : Shared posit-unit widths, special encodings and the unpacked
//            operand record used between datapath front ends and the encoder.
// Revision : 1.0 - initial release
// ============================================================================
package ppu_pkg;

  localparam int PPU_N  = 32;
  localparam int PPU_ES = 2;
  localparam int PPU_FW = 32;
  localparam int PPU_SW = $clog2(PPU_N) + PPU_ES + 2;

  localparam logic [PPU_N-1:0] MAXPOS = {1'b0, {(PPU_N-1){1'b1}}};
  localparam logic [PPU_N-1:0] MINPOS = {{(PPU_N-1){1'b0}}, 1'b1};
  localparam logic [PPU_N-1:0] NAR    = {1'b1, {(PPU_N-1){1'b0}}};

  typedef struct packed {
    logic                     sign;
    logic                     zero;
    logic                     nar;
    logic signed [PPU_SW-1:0] scale;
    logic [PPU_FW-1:0]        frac;
    logic                     sticky;
  } unpacked_t;

endpackage
`default_nettype wire

// File: rtl/posit_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : posit_round_sat
// Brief    : Round-to-nearest-even of a packed posit body, clamping to
//            [minpos, maxpos], special-value override and final negation.
// Revision : 1.0 - initial release
// ============================================================================
module posit_round_sat
  import ppu_pkg::*;
#(
  parameter int N = PPU_N
) (
  input  logic         i_sign,
  input  logic         i_zero,
  input  logic         i_nar,
  input  logic         i_sat_hi,
  input  logic         i_sat_lo,
  input  logic [N-2:0] i_body,
  input  logic         i_guard,
  input  logic         i_sticky,
  output logic [N-1:0] o_posit
);

  logic [N-1:0] w_maxpos;
  logic [N-1:0] w_minpos;
  logic [N-1:0] w_nar;

  generate
    if (N == PPU_N) begin : g_pkg_consts
      assign w_maxpos = MAXPOS;
      assign w_minpos = MINPOS;
      assign w_nar    = NAR;
    end else begin : g_local_consts
      assign w_maxpos = {1'b0, {(N-1){1'b1}}};
      assign w_minpos = {{(N-1){1'b0}}, 1'b1};
      assign w_nar    = {1'b1, {(N-1){1'b0}}};
    end
  endgenerate

  logic         w_round_up;
  logic [N-1:0] w_sum;
  logic [N-1:0] w_mag;

  assign w_round_up = i_guard & (i_body[0] | i_sticky);
  assign w_sum      = {1'b0, i_body} + {{(N-1){1'b0}}, w_round_up};

  always_comb begin
    w_mag = w_sum;
    // A carry into the sign position means we rounded past maxpos.
    if (w_sum[N-1]) begin
      w_mag = w_maxpos;
    end else if (w_sum == '0) begin
      w_mag = w_minpos;
    end
    if (i_sat_hi) begin
      w_mag = w_maxpos;
    end else if (i_sat_lo) begin
      w_mag = w_minpos;
    end

    o_posit = i_sign ? -w_mag : w_mag;
    if (i_zero) begin
      o_posit = '0;
    end
    if (i_nar) begin
      o_posit = w_nar;
    end
  end

endmodule
`default_nettype wire

// File: rtl/posit_encoder.sv
`default_nettype none
// ============================================================================
// Module   : posit_encoder
// Brief    : Two-stage pipelined posit packer (pack -> round/sign) with a
//            valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module posit_encoder
  import ppu_pkg::*;
#(
  parameter int N  = PPU_N,
  parameter int ES = PPU_ES,
  parameter int FW = PPU_FW,
  parameter int SW = $clog2(N) + ES + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  input  logic          in_sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);

  localparam int c_len     = 2 + ES + FW + N;
  localparam int c_max_int = (N - 2) * (2 ** ES);
  localparam int c_min_int = -c_max_int;
  localparam logic signed [SW-1:0] c_max_scale = c_max_int[SW-1:0];
  localparam logic signed [SW-1:0] c_min_scale = c_min_int[SW-1:0];

  // Handshake
  logic w_s1_adv;
  logic w_s2_adv;
  logic r_s1_valid;
  logic r_s2_valid;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;

  // Stage 1: clamp, regime/exponent split and barrel shift
  logic signed [SW-1:0] w_scale;
  logic signed [SW-1:0] w_scale_c;
  logic signed [SW-1:0] w_k;
  logic [SW-1:0]        w_amt;
  logic [ES-1:0]        w_e;
  logic [1:0]           w_head;
  logic [c_len-1:0]     w_str;
  logic [c_len-1:0]     w_shifted;
  logic                 w_sat_hi;
  logic                 w_sat_lo;
  logic [N-2:0]         w_body;
  logic                 w_guard;
  logic                 w_sticky;

  assign w_scale   = in_scale;
  assign w_sat_hi  = w_scale > c_max_scale;
  assign w_sat_lo  = w_scale < c_min_scale;
  assign w_scale_c = w_sat_hi ? c_max_scale : (w_sat_lo ? c_min_scale : w_scale);
  assign w_k       = w_scale_c >>> ES;
  assign w_e       = w_scale_c[ES-1:0];

  // Head "10" arithmetically shifted by k yields k+1 ones then a zero;
  // head "01" shifted by -k-1 (= ~k) yields -k zeros then a one.
  assign w_head    = w_k[SW-1] ? 2'b01 : 2'b10;
  assign w_amt     = w_k[SW-1] ? ~w_k : w_k;
  assign w_str     = {w_head, w_e, in_frac, {N{1'b0}}};
  assign w_shifted = $signed(w_str) >>> w_amt;

  assign w_body    = w_shifted[c_len-1 -: N-1];
  assign w_guard   = w_shifted[c_len-N];
  assign w_sticky  = (|w_shifted[c_len-N-1:0]) | in_sticky;

  logic         r_s1_sign;
  logic         r_s1_zero;
  logic         r_s1_nar;
  logic         r_s1_sat_hi;
  logic         r_s1_sat_lo;
  logic [N-2:0] r_s1_body;
  logic         r_s1_guard;
  logic         r_s1_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_nar    <= 1'b0;
      r_s1_sat_hi <= 1'b0;
      r_s1_sat_lo <= 1'b0;
      r_s1_body   <= '0;
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign   <= in_sign;
        r_s1_zero   <= in_zero;
        r_s1_nar    <= in_nar;
        r_s1_sat_hi <= w_sat_hi;
        r_s1_sat_lo <= w_sat_lo;
        r_s1_body   <= w_body;
        r_s1_guard  <= w_guard;
        r_s1_sticky <= w_sticky;
      end
    end
  end

  // Stage 2: round, saturate, sign
  logic [N-1:0] w_s2_posit;
  logic [N-1:0] r_s2_posit;

  posit_round_sat #(
    .N (N)
  ) u_round_sat (
    .i_sign   (r_s1_sign),
    .i_zero   (r_s1_zero),
    .i_nar    (r_s1_nar),
    .i_sat_hi (r_s1_sat_hi),
    .i_sat_lo (r_s1_sat_lo),
    .i_body   (r_s1_body),
    .i_guard  (r_s1_guard),
    .i_sticky (r_s1_sticky),
    .o_posit  (w_s2_posit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_posit <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_posit <= w_s2_posit;
      end
    end
  end

  assign out_posit = r_s2_posit;

endmodule
`default_nettype wire

// File: tb/tb_posit_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_posit_encoder
// Brief    : Directed and randomized checks of posit_encoder against an
//            independent bit-string posit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_posit_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic        in_zero;
  logic        in_nar;
  logic [8:0]  in_scale;
  logic [31:0] in_frac;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_posit;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cur_scale;
  logic [31:0] exp_q[$];

  posit_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posit(32,2) value built as an explicit bit string: regime, exponent, fraction.
  function automatic logic [31:0] ref_posit(input logic sgn, input logic zro, input logic nr,
                                            input int scale, input logic [31:0] frac,
                                            input logic stk);
    logic [31:0] mag;
    longint      body;
    bit          q[$];
    int          k;
    int          e;
    bit          guard;
    bit          st;
    if (nr) return 32'h8000_0000;
    if (zro) return 32'h0000_0000;
    if (scale > 120) begin
      mag = 32'h7FFF_FFFF;
    end else if (scale < -120) begin
      mag = 32'h0000_0001;
    end else begin
      e = ((scale % 4) + 4) % 4;
      k = (scale - e) / 4;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(e[1]);
      q.push_back(e[0]);
      for (int i = 31; i >= 0; i--) q.push_back(frac[i]);
      body = 0;
      for (int i = 0; i < 31; i++) body = body * 2 + longint'(q[i]);
      guard = q[31];
      st = stk;
      for (int i = 32; i < q.size(); i++) st = st | q[i];
      if (guard && (body[0] || st)) body = body + 1;
      if (body > 64'h7FFF_FFFF) body = 64'h7FFF_FFFF;
      if (body == 0) body = 1;
      mag = body[31:0];
    end
    return sgn ? (32'h0 - mag) : mag;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic directed(input string tag, input logic sgn, input logic zro, input logic nr,
                          input int scale, input logic [31:0] frac, input logic stk,
                          input logic [31:0] expv);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sign   = sgn;
    in_zero   = zro;
    in_nar    = nr;
    in_scale  = scale[8:0];
    in_frac   = frac;
    in_sticky = stk;
    out_ready = 1'b1;
    #1 check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({tag, "/lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "/valid"}, 32'(out_valid), 32'd1);
    check(tag, out_posit, expv);
  endtask

  task automatic stream(input int count, input bit pattern);
    int          sent = 0;
    int          cyc = 0;
    bit          hold = 0;
    bit          in_fire = 0;
    bit          out_fire = 0;
    logic [31:0] prev = '0;
    in_valid = 1'b0;
    while ((sent < count || exp_q.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      if (in_fire) in_valid = 1'b0;
      if (!in_valid && sent < count) begin
        in_sign   = 1'($urandom_range(0, 1));
        in_zero   = ($urandom_range(0, 15) == 0);
        in_nar    = ($urandom_range(0, 15) == 0);
        cur_scale = int'($urandom_range(0, 300)) - 150;
        in_scale  = cur_scale[8:0];
        in_frac   = $urandom;
        in_sticky = 1'($urandom_range(0, 1));
        in_valid  = 1'b1;
      end
      out_ready = pattern ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
      #1;
      check("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 2 && !out_ready)));
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_posit", out_posit, prev);
      end
      out_fire = out_valid && out_ready;
      in_fire  = in_valid && in_ready;
      if (out_fire) begin
        if (exp_q.size() == 0) check("spurious", 32'(out_valid), 32'd0);
        else check("stream", out_posit, exp_q.pop_front());
      end
      if (in_fire) begin
        exp_q.push_back(ref_posit(in_sign, in_zero, in_nar, cur_scale, in_frac, in_sticky));
        sent++;
      end
      hold = out_valid && !out_ready;
      prev = out_posit;
      cyc++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    check("sent", 32'(sent), 32'(count));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_zero   = 1'b0;
    in_nar    = 1'b0;
    in_scale  = '0;
    in_frac   = '0;
    in_sticky = 1'b0;
    out_ready = 1'b1;
    cur_scale = 0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_posit", out_posit, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    directed("scale0",       1'b0, 1'b0, 1'b0,    0, 32'h0,  1'b0, 32'h4000_0000);
    directed("scale1",       1'b0, 1'b0, 1'b0,    1, 32'h0,  1'b0, 32'h4800_0000);
    directed("scale_m1",     1'b0, 1'b0, 1'b0,   -1, 32'h0,  1'b0, 32'h3800_0000);
    directed("scale4",       1'b0, 1'b0, 1'b0,    4, 32'h0,  1'b0, 32'h6000_0000);
    directed("neg_scale0",   1'b1, 1'b0, 1'b0,    0, 32'h0,  1'b0, 32'hC000_0000);
    directed("nar_pos",      1'b0, 1'b0, 1'b1,   37, 32'h5,  1'b0, 32'h8000_0000);
    directed("nar_neg",      1'b1, 1'b0, 1'b1,   -3, 32'h0,  1'b1, 32'h8000_0000);
    directed("nar_over_zero",1'b0, 1'b1, 1'b1,    0, 32'h0,  1'b0, 32'h8000_0000);
    directed("zero_neg",     1'b1, 1'b1, 1'b0,   10, 32'hF,  1'b0, 32'h0000_0000);
    directed("sat120",       1'b0, 1'b0, 1'b0,  120, 32'h0,  1'b0, 32'h7FFF_FFFF);
    directed("sat200",       1'b0, 1'b0, 1'b0,  200, 32'h0,  1'b0, 32'h7FFF_FFFF);
    directed("sat_m120",     1'b0, 1'b0, 1'b0, -120, 32'h0,  1'b0, 32'h0000_0001);
    directed("sat_m200",     1'b0, 1'b0, 1'b0, -200, 32'h0,  1'b0, 32'h0000_0001);
    directed("sat_m200_neg", 1'b1, 1'b0, 1'b0, -200, 32'h0,  1'b0, 32'hFFFF_FFFF);
    directed("rnd_tie_even", 1'b0, 1'b0, 1'b0,    0, 32'h10, 1'b0, 32'h4000_0000);
    directed("rnd_tie_odd",  1'b0, 1'b0, 1'b0,    0, 32'h30, 1'b0, 32'h4000_0002);
    directed("rnd_sticky",   1'b0, 1'b0, 1'b0,    0, 32'h10, 1'b1, 32'h4000_0001);

    stream(8, 1'b1);
    stream(150, 1'b0);

    // Fill both stages under backpressure, then reset asynchronously.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sign   = 1'b0;
    in_zero   = 1'b0;
    in_nar    = 1'b0;
    in_scale  = 9'd8;
    in_frac   = 32'h0;
    in_sticky = 1'b0;
    @(negedge clk);
    in_scale = 9'd12;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_posit", out_posit, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    directed("post_rst", 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 32'h4000_0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("post_rst_idle", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
- Pipelined posit packer: takes an unpacked result (sign, scale, fraction, sticky, special flags) and produces a rounded N-bit posit.
- It does the reverse of the operand decode at the front of the Divider and other PPU units. It is the shared back end for the iterative divider, multiplier and adder datapaths.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- N, 32, posit width in bits.
- ES, 2, exponent field width.
- FW, 32, width of the incoming fraction, MSB-aligned, hidden bit excluded.
- SW, $clog2(N)+ES+2, width of the signed scale input (9 for defaults).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  unpacked operand valid.
- in_ready  output  1  encoder can accept the operand this cycle.
- in_sign  input  1  result sign (1 = negative).
- in_zero  input  1  result is exactly zero.
- in_nar  input  1  result is NaR (Not a Real).
- in_scale  input  SW  signed scale, equal to k*2^ES + e.
- in_frac  input  FW  fraction bits after the hidden 1, MSB first.
- in_sticky  input  1  OR of all fraction bits discarded upstream.
- out_valid  output  1  out_posit is valid.
- out_ready  input  1  downstream accepts out_posit.
- out_posit  output  N  encoded posit, two's-complement form for negatives.

Behaviour:
- Reset (async assert, sync release):
  - s1_valid = s2_valid = 0.
  - out_posit = 0.
  - out_valid = 0.
  - in_ready = 1 once reset is released.
- Handshake:
  - A transfer happens on any edge where valid && ready.
  - Stage advance: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational, no bubble).
  - A stalled stage holds all of its registers unchanged.
  - out_posit is stable while out_valid && !out_ready.
- Latency and throughput: exactly 2 cycles from input acceptance to out_valid when not stalled; throughput 1 per cycle.
- Stage 1 (pack):
  - Clamp scale to ±(N-2)*2^ES and record a saturation flag.
  - k = scale >>> ES (arithmetic shift); e = scale[ES-1:0].
  - Regime: k>=0 gives k+1 ones then a 0; k<0 gives -k zeros then a 1.
  - Build the magnitude string regime|e|in_frac.
  - Barrel-shift the string into an N-1 bit body plus guard bit plus sticky (OR of the bits below the guard and in_sticky).
- Stage 2 (round/sign):
  - Round to nearest, ties to even: increment if guard && (lsb || sticky).
  - Never round a nonzero value to 0: magnitude 0 becomes minpos (1).
  - Never round up past maxpos: result is 0x7FFF..F.
  - Saturation flag forces maxpos (scale > max) or minpos (scale < -max).
  - Negate (two's complement) if in_sign.
- Special-value priority: in_nar first, out = 1 followed by zeros (0x80000000); then in_zero, out = 0; in_sign ignored for both.
- Reset mid-operation: in-flight results are discarded, no output is produced for them, and the next accepted input behaves as if from cold.

Decomposition:
- Shared package ppu_pkg holds:
  - N, ES, SW defaults.
  - localparams MAXPOS, MINPOS, NAR.
  - typedef unpacked_t {sign, zero, nar, scale, frac, sticky}, reused by the divider and multiplier front ends.
- One sub-module, posit_round_sat: combinational stage-2 rounding, saturation and negation, instantiated inside the stage-2 register.

Test Plan:
- Scale 0, frac 0, sign 0 -> 0x40000000 on out_valid exactly 2 cycles later; scale 1 -> 0x48000000; scale -1 -> 0x38000000; scale 4 -> 0x60000000.
- Scale 0, frac 0, sign 1 -> 0xC0000000. Negative flags:
  - in_nar=1 (any sign) -> 0x80000000.
  - in_zero=1, sign 1 -> 0x00000000.
- Saturation:
  - Scale 120 -> 0x7FFFFFFF.
  - Scale 200 -> 0x7FFFFFFF.
  - Scale -200 -> 0x00000001.
  - Scale -200 with sign 1 -> 0xFFFFFFFF.
- Rounding at scale 0:
  - frac = 0x00000010 (guard only) -> 0x40000000 (tie to even).
  - frac = 0x00000030 -> 0x40000002.
  - frac = 0x00000010 with in_sticky=1 -> 0x40000001.
- Backpressure: stream 8 back-to-back values with out_ready toggling 1,0,0,1,... -> outputs appear in order, no loss or duplication, out_posit holds during stall, in_ready drops only when both stages are full.
- Assert rst_n low with both stages valid -> out_valid and out_posit go to 0 immediately. After release, one input with scale 0 -> exactly one output 0x40000000.
